// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick driven h/v counters with registered sync, enable and marker outputs.
// Optional completed-frame counter port enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 10,
    parameter int FC_W      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          pix_vld
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FC_W-1:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          h_wrap;
    logic          v_wrap;
    logic          in_act;
    logic          in_hs;
    logic          in_vs;

    // Decode of the current (pre-increment) position; this is what gets registered onto the outputs.
    always_comb begin
        h_wrap = (h == H_LAST);
        v_wrap = (v == V_LAST);
        h_next = h_wrap ? '0 : h + CW'(1);
        v_next = v;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v + CW'(1);
        end
        in_act = (h < H_ACT) && (v < V_ACT);
        in_hs  = (h >= HS_BEG) && (h < HS_END);
        in_vs  = (v >= VS_BEG) && (v < VS_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            pix_vld     <= 1'b0;
        end else begin
            pix_vld <= pix_en;
            if (pix_en) begin
                h           <= h_next;
                v           <= v_next;
                x           <= h;
                y           <= v;
                de          <= in_act;
                hsync       <= in_hs ? HSYNC_POL : ~HSYNC_POL;
                vsync       <= in_vs ? VSYNC_POL : ~VSYNC_POL;
                line_start  <= (h == '0);
                frame_start <= (h == '0) && (v == '0);
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Counts on the tick that leaves the last pixel of the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (pix_en && h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + FC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default 640x480, a medium config for full-frame vsync, and a tiny
// strobed config; builds with or without VGA_TIMING_FRAME_CNT_EN.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic       pv;
        logic [9:0] y;
        logic [9:0] x;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstD = 1'b1, pixEnD = 1'b1;
    logic rstM = 1'b1, pixEnM = 1'b1;
    logic rstS = 1'b1, pixEnS = 1'b1;

    logic hsD, vsD, deD, lsD, fsD, pvD;
    logic hsM, vsM, deM, lsM, fsM, pvM;
    logic hsS, vsS, deS, lsS, fsS, pvS;
    logic [9:0] xD, yD, xM, yM, xS, yS;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] fcD, fcM;
    logic [1:0] fcS;
`endif

    int checks = 0;
    int passes = 0;

    vga_timing_gen dutD (
        .clk(clk), .rst(rstD), .pix_en(pixEnD),
        .hsync(hsD), .vsync(vsD), .de(deD), .x(xD), .y(yD),
        .line_start(lsD), .frame_start(fsD), .pix_vld(pvD)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fcD)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(3), .V_SYNC(2), .V_BP(5)
    ) dutM (
        .clk(clk), .rst(rstM), .pix_en(pixEnM),
        .hsync(hsM), .vsync(vsM), .de(deM), .x(xM), .y(yM),
        .line_start(lsM), .frame_start(fsM), .pix_vld(pvM)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fcM)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(10), .FC_W(2)
    ) dutS (
        .clk(clk), .rst(rstS), .pix_en(pixEnS),
        .hsync(hsS), .vsync(vsS), .de(deS), .x(xS), .y(yS),
        .line_start(lsS), .frame_start(fsS), .pix_vld(pvS)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fcS)
`endif
    );

    out_t actD, actM, actS;
    assign actD = {hsD, vsD, deD, lsD, fsD, pvD, yD, xD};
    assign actM = {hsM, vsM, deM, lsM, fsM, pvM, yM, xM};
    assign actS = {hsS, vsS, deS, lsS, fsS, pvS, yS, xS};

    function automatic out_t mk(bit hs, bit vs, bit de, bit ls, bit fs, bit pv, int yy, int xx);
        out_t r;
        r.hs = hs; r.vs = vs; r.de = de; r.ls = ls; r.fs = fs; r.pv = pv;
        r.y = 10'(yy); r.x = 10'(xx);
        return r;
    endfunction

    // Position of the t-th pixel tick since reset, decoded straight from the timing rules.
    function automatic out_t modelPix(int t, int ha, int hf, int hsw, int hb,
                                      int va, int vf, int vsw, int vb, bit hp, bit vp);
        int ht, vt, h, v;
        out_t r;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        h  = t % ht;
        v  = (t / ht) % vt;
        r.x  = 10'(h);
        r.y  = 10'(v);
        r.de = (h < ha) && (v < va);
        r.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
        r.vs = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
        r.ls = (h == 0);
        r.fs = (h == 0) && (v == 0);
        r.pv = 1'b1;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    out_t expD, expM, expS;
    int tickD = 0, tickM = 0, tickS = 0;
    bit initD = 0, initM = 0, initS = 0;

    always @(posedge clk) begin
        if (rstD) begin
            expD = mk(1, 1, 0, 0, 0, 0, 0, 0); tickD = 0; initD = 1;
        end else if (pixEnD) begin
            expD = modelPix(tickD, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0); tickD++;
        end else expD.pv = 1'b0;

        if (rstM) begin
            expM = mk(1, 1, 0, 0, 0, 0, 0, 0); tickM = 0; initM = 1;
        end else if (pixEnM) begin
            expM = modelPix(tickM, 64, 4, 8, 4, 48, 3, 2, 5, 0, 0); tickM++;
        end else expM.pv = 1'b0;

        if (rstS) begin
            expS = mk(0, 0, 0, 0, 0, 0, 0, 0); tickS = 0; initS = 1;
        end else if (pixEnS) begin
            expS = modelPix(tickS, 4, 1, 2, 1, 3, 1, 1, 1, 1, 1); tickS++;
        end else expS.pv = 1'b0;
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (initD) checkOutput("modelD", 32'(actD), 32'(expD));
        if (initM) checkOutput("modelM", 32'(actM), 32'(expM));
        if (initS) checkOutput("modelS", 32'(actS), 32'(expS));
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (initS) checkOutput("modelFcS", 32'(fcS), 32'((tickS / 48) % 4));
`endif
    end

    task automatic applyStimulus(input int unit, input logic r, input logic e);
        case (unit)
            0: begin rstD = r; pixEnD = e; end
            1: begin rstM = r; pixEnM = e; end
            default: begin rstS = r; pixEnS = e; end
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("resetD", 32'(actD), 32'(mk(1, 1, 0, 0, 0, 0, 0, 0)));
        checkOutput("resetS", 32'(actS), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
`ifdef VGA_TIMING_FRAME_CNT_EN
        checkOutput("resetFcS", 32'(fcS), 32'd0);
`endif
        rstD = 0; rstM = 0; rstS = 0;
        pixEnD = 0; pixEnM = 0; pixEnS = 0;

        // Default 640x480, continuous pixel ticks.
        for (int k = 1; k <= 901; k++) begin
            applyStimulus(0, 1'b0, 1'b1);
            case (k)
                1:   checkOutput("D_tick1",   32'(actD), 32'(mk(1, 1, 1, 1, 1, 1, 0, 0)));
                640: checkOutput("D_x639",    32'(actD), 32'(mk(1, 1, 1, 0, 0, 1, 0, 639)));
                641: checkOutput("D_deFall",  32'(actD), 32'(mk(1, 1, 0, 0, 0, 1, 0, 640)));
                656: checkOutput("D_x655",    32'(actD), 32'(mk(1, 1, 0, 0, 0, 1, 0, 655)));
                657: checkOutput("D_hsOn",    32'(actD), 32'(mk(0, 1, 0, 0, 0, 1, 0, 656)));
                752: checkOutput("D_hsLast",  32'(actD), 32'(mk(0, 1, 0, 0, 0, 1, 0, 751)));
                753: checkOutput("D_hsOff",   32'(actD), 32'(mk(1, 1, 0, 0, 0, 1, 0, 752)));
                801: checkOutput("D_line1",   32'(actD), 32'(mk(1, 1, 1, 1, 0, 1, 1, 0)));
                901: checkOutput("D_x100",    32'(actD), 32'(mk(1, 1, 1, 0, 0, 1, 1, 100)));
                default: ;
            endcase
        end
        applyStimulus(0, 1'b1, 1'b1);
        checkOutput("D_midRst", 32'(actD), 32'(mk(1, 1, 0, 0, 0, 0, 0, 0)));
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("D_afterRst", 32'(actD), 32'(mk(1, 1, 1, 1, 1, 1, 0, 0)));
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("D_hold", 32'(actD), 32'(mk(1, 1, 1, 1, 1, 0, 0, 0)));

        // Medium config (80 x 58): full frame, vsync on lines 51..52.
        for (int k = 1; k <= 4641; k++) begin
            applyStimulus(1, 1'b0, 1'b1);
            case (k)
                4080: checkOutput("M_line50end", 32'(actM), 32'(mk(1, 1, 0, 0, 0, 1, 50, 79)));
                4081: checkOutput("M_vsOn",      32'(actM), 32'(mk(1, 0, 0, 1, 0, 1, 51, 0)));
                4230: checkOutput("M_vsHs",      32'(actM), 32'(mk(0, 0, 0, 0, 0, 1, 52, 69)));
                4241: checkOutput("M_vsOff",     32'(actM), 32'(mk(1, 1, 0, 1, 0, 1, 53, 0)));
                4641: checkOutput("M_frame2",    32'(actM), 32'(mk(1, 1, 1, 1, 1, 1, 0, 0)));
                default: ;
            endcase
        end
        applyStimulus(1, 1'b0, 1'b0);

        // Tiny config (8 x 6, active-high syncs), strobe every third clock.
        for (int s = 1; s <= 200; s++) begin
            applyStimulus(2, 1'b0, 1'b1);
            case (s)
                6:  checkOutput("S_hsOn",   32'(actS), 32'(mk(1, 0, 0, 0, 0, 1, 0, 5)));
                7:  checkOutput("S_hsLast", 32'(actS), 32'(mk(1, 0, 0, 0, 0, 1, 0, 6)));
                8:  checkOutput("S_hsOff",  32'(actS), 32'(mk(0, 0, 0, 0, 0, 1, 0, 7)));
                33: checkOutput("S_vsOn",   32'(actS), 32'(mk(0, 1, 0, 1, 0, 1, 4, 0)));
                49: checkOutput("S_frame2", 32'(actS), 32'(mk(0, 0, 1, 1, 1, 1, 0, 0)));
                default: ;
            endcase
`ifdef VGA_TIMING_FRAME_CNT_EN
            case (s)
                47:  checkOutput("S_fc47",  32'(fcS), 32'd0);
                48:  checkOutput("S_fc48",  32'(fcS), 32'd1);
                96:  checkOutput("S_fc96",  32'(fcS), 32'd2);
                144: checkOutput("S_fc144", 32'(fcS), 32'd3);
                192: checkOutput("S_fc192", 32'(fcS), 32'd0);
                default: ;
            endcase
`endif
            applyStimulus(2, 1'b0, 1'b0);
            if (s == 8) checkOutput("S_pvDrop", 32'(actS), 32'(mk(0, 0, 0, 0, 0, 0, 0, 7)));
            applyStimulus(2, 1'b0, 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the TinyTapeout VGA controller top level. Sits between the top-level clock/reset and the pixel/colour pipeline. Produces registered hsync, vsync, display-enable, pixel coordinates and line/frame start markers for any resolution and porch set. Advances on a pixel-clock-enable strobe, so one system clock can drive several pixel rates.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)
- CW, 10, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FC_W, 8, frame counter width (used only with VGA_TIMING_FRAME_CNT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel tick; counters and outputs advance only when high
- hsync  out  1  horizontal sync at HSYNC_POL level when active
- vsync  out  1  vertical sync at VSYNC_POL level when active
- de  out  1  display enable, high inside the active area
- x  out  CW  horizontal counter value of the current pixel
- y  out  CW  vertical counter value of the current pixel
- line_start  out  1  high for the pixel with h == 0
- frame_start  out  1  high for the pixel with h == 0 and v == 0
- pix_vld  out  1  one-clk pulse: outputs were updated this cycle
- frame_cnt  out  FC_W  completed-frame count (only with VGA_TIMING_FRAME_CNT_EN)

One clock; reset is synchronous and active-high.

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters h and v form the state. On a clk edge with pix_en=1:
  - h wraps H_TOTAL-1 -> 0, otherwise increments.
  - v increments only when h wraps, and wraps V_TOTAL-1 -> 0.
- Output stage, on the same edge, registers the decode of the pre-increment (h, v):
  - x = h, y = v; x and y are not masked outside the active area.
  - de = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vsync is line-granular: it changes only together with h = 0 pixels.
  - line_start = (h == 0); frame_start = (h == 0 && v == 0).
- With pix_en=0: counters and all outputs except pix_vld hold. pix_vld = registered pix_en.
- Reset values: h=0, v=0, x=0, y=0, de=0, line_start=0, frame_start=0, pix_vld=0. hsync = ~HSYNC_POL and vsync = ~VSYNC_POL (inactive). frame_cnt=0.
- Reset mid-frame discards position. The next pix_en reports h=0, v=0: de=1, line_start=1, frame_start=1.
- rst has priority over pix_en in the same cycle.

## Timing
- Latency: outputs describe pixel (h, v) one clk after the edge that samples pix_en=1 at that position.
- Pixel-rate outputs hold for a full pixel period. Consumers qualify line_start and frame_start with pix_vld.
- pix_en held high gives one pixel per clk. Any strobe pattern is legal; the frame length in ticks is always H_TOTAL*V_TOTAL.
- Default 640x480: H_TOTAL=800, V_TOTAL=525.
  - hsync active at h 656..751; vsync active at v 490..491.
  - Frame = 420000 ticks.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - Port frame_cnt exists.
  - frame_cnt increments on the pix_en edge where h = H_TOTAL-1 and v = V_TOTAL-1 (frame wrap).
  - It wraps 2^FC_W-1 -> 0 and resets to 0.
- Not defined: port frame_cnt and its register are absent; FC_W is ignored.

## Test plan
- Reset: hold rst=1 for 3 clks with pix_en=1 -> hsync=1, vsync=1, de=0, x=0, y=0, line_start=0, frame_start=0, pix_vld=0.
- Default params, pix_en=1 continuous after reset:
  - Tick 1 gives x=0, y=0, de=1, frame_start=1.
  - de falls at x=640.
  - hsync low exactly for x 656..751.
  - Tick 801 gives x=0, y=1, line_start=1, frame_start=0.
- Full frame: vsync low exactly on lines 490..491; frame_start recurs at tick 420001.
- Small config (H 4/1/2/1, V 3/1/1/1, HSYNC_POL=1, VSYNC_POL=1), pix_en every 3rd clk:
  - Outputs change only in cycles after a strobe; pix_vld is one clk wide.
  - hsync high at x 5..6; frame = 48 strobes.
- Mid-frame reset at x=100, y=200 -> next strobe reports x=0, y=0, frame_start=1.
- VGA_TIMING_FRAME_CNT_EN, small config, FC_W=2: frame_cnt steps 0,1,2,3,0 at each frame wrap.
